// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR MAC kernel and its tap sequencer.
package fir_pkg;
    localparam int FIR_DW   = 32;
    localparam int FIR_NTAP = 11;

    localparam logic [3:0] PHASE_RST    = 4'd1;
    localparam logic [3:0] PHASE_DONE   = 4'd11;
    localparam logic [3:0] PHASE_ACCEPT = 4'd10;

    typedef logic [FIR_DW-1:0] fir_word_t;
endpackage

// File: rtl/fir_phase_ctr.sv
// 1..11 wrap counter mirroring the kernel's Done counter, with decoded strobes.
module fir_phase_ctr
    import fir_pkg::*;
(
    input  logic       CLK,
    input  logic       Resetn,
    output logic [3:0] phase,
    output logic       done,
    output logic       accept_slot
);

    logic [3:0] phase_nxt;

    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            phase <= PHASE_RST;
        end else begin
            phase <= phase_nxt;
        end
    end

    always_comb begin
        phase_nxt = phase + 4'd1;
        if (phase == PHASE_DONE) begin
            phase_nxt = PHASE_RST;
        end
    end

    assign done        = (phase == PHASE_DONE);
    assign accept_slot = (phase == PHASE_ACCEPT);

endmodule

// File: rtl/fir_tap_sequencer.sv
// Feeds the 11-cycle FIR MAC kernel: sample history, coefficient bank and
// per-cycle X/tap operands in lockstep with the kernel phase.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int DW   = FIR_DW,
    parameter int NTAP = FIR_NTAP
) (
    input  logic          CLK,
    input  logic          Resetn,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          tap_we,
    input  logic [3:0]    tap_addr,
    input  logic [DW-1:0] tap_wdata,
    input  logic          hist_clr,
    output logic [DW-1:0] X,
    output logic [DW-1:0] tap,
    output logic          y_valid
);

    logic [3:0]    phase;
    logic          done;
    logic          accept_slot;
    logic [3:0]    idx;
    logic          accept;
    logic          win_live;
    logic          res_live;
    logic [DW-1:0] hist [NTAP];
    logic [DW-1:0] taps [NTAP];

    fir_phase_ctr u_phase (
        .CLK         (CLK),
        .Resetn      (Resetn),
        .phase       (phase),
        .done        (done),
        .accept_slot (accept_slot)
    );

    // Handshake: s_ready is high only in the phase-10 slot; a sample transfers
    // on the rising edge where s_valid & s_ready, otherwise the producer holds it.
    assign s_ready = accept_slot;
    assign accept  = s_valid & accept_slot;

    // The Done cycle doubles as the first product slot of the next window.
    always_comb begin
        idx = phase;
        if (done) begin
            idx = 4'd0;
        end
    end

    assign tap     = taps[idx];
    assign X       = win_live ? hist[idx] : '0;
    assign y_valid = done & res_live;

    // Clear takes priority over the shift, so a simultaneous accept lands alone.
    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            for (int k = 0; k < NTAP; k++) begin
                hist[k] <= '0;
            end
        end else if (accept) begin
            hist[0] <= s_data;
            for (int k = 1; k < NTAP; k++) begin
                hist[k] <= hist_clr ? '0 : hist[k-1];
            end
        end else if (hist_clr) begin
            for (int k = 0; k < NTAP; k++) begin
                hist[k] <= '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            for (int k = 0; k < NTAP; k++) begin
                taps[k] <= '0;
            end
        end else if (tap_we && (tap_addr < 4'(NTAP))) begin
            taps[tap_addr] <= tap_wdata;
        end
    end

    // res_live marks the window whose result the kernel reports at the next Done.
    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            win_live <= 1'b0;
            res_live <= 1'b0;
        end else if (accept_slot) begin
            res_live <= win_live;
            win_live <= accept;
        end
    end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Upstream feeder for the free-running 11-cycle FIR MAC kernel.
- Accepts one input sample per 11-cycle window over a valid/ready handshake and holds an 11-deep sample history plus an 11-entry coefficient bank.
- Each cycle it drives the X/tap product pair the kernel needs, in lockstep with the kernel's internal phase.
- Flags which kernel Done cycles carry a result for a real sample.

Parameters:
- DW, 32, sample and coefficient width; must match the kernel's 32-bit X/tap.
- NTAP, 11, taps per window; fixed by the kernel period, so any other value is unsupported.

Ports:
- CLK  in  1  system clock, shared with the kernel.
- Resetn  in  1  asynchronous active-low reset; the same net drives the kernel.
- s_data  in  DW  input sample.
- s_valid  in  1  sample-present strobe.
- s_ready  out  1  high only in the acceptance slot.
- tap_we  in  1  coefficient write strobe.
- tap_addr  in  4  coefficient index, 0..10.
- tap_wdata  in  DW  coefficient value.
- hist_clr  in  1  synchronous clear of the sample history.
- X  out  DW  sample operand to the kernel.
- tap  out  DW  coefficient operand to the kernel.
- y_valid  out  1  high during a kernel Done cycle whose Y belongs to an accepted sample.

Behaviour:
- Interface: one clock (CLK); reset (Resetn) is asynchronous and active-low.
- Phase counter `phase`, 4 bits:
  - Resets to 1, exactly mirroring the kernel's Done counter.
  - Increments each cycle 1→2→…→11, then 11→1.
  - phase==11 is the kernel Done cycle and the first product slot of a new window.
- Operand index: idx = 0 when phase==11, else idx = phase. A window is therefore idx 0,1,…,10 over 11 consecutive cycles.
- Combinational outputs:
  - tap = taps[idx].
  - X = win_live ? hist[idx] : 0.
- History orientation: hist[0] holds the newest sample x[n]; hist[k] holds x[n-k].
- Handshake:
  - s_ready = (phase==10).
  - accept = s_valid & s_ready.
  - At that edge the history shifts: hist[k] <= hist[k-1] for k=1..10, and hist[0] <= s_data.
  - s_valid outside phase 10 is ignored and the sample is held by the producer.
  - Zero-valued samples must still be sent to advance the history.
- Window tracking, updated at the phase-10 edge:
  - res_live <= win_live.
  - win_live <= accept.
  - y_valid = (phase==11) & res_live.
- No-sample window: X is forced to 0, so the kernel produces Y=0, and y_valid stays low one window later.
- Latency: a sample accepted at the end of cycle c (phase 10) has its window in cycles c+1..c+11. Its result appears with y_valid=1 in cycle c+12.
- Coefficient writes:
  - On tap_we, taps[tap_addr] <= tap_wdata, visible from the next cycle.
  - tap_addr > 10 is ignored.
  - A write during a live window takes effect mid-window and produces a mixed-coefficient result. Firmware updates taps only while the producer holds off s_valid; no hardware interlock is provided.
- hist_clr:
  - Clears hist[0..10] to 0 at the next edge.
  - If it coincides with accept, the clear applies first, so hist[0]=s_data and the other entries are 0.
  - It does not affect win_live or res_live.
- Reset values: phase=1, hist=0, taps=0, win_live=0, res_live=0.
  - Resulting outputs: X=0, tap=0, s_ready=0, y_valid=0.
- Reset mid-operation: all state returns to its reset values immediately. Because the kernel shares Resetn, lockstep is preserved and no partial result is flagged valid.
- Arithmetic: no arithmetic in this block. Operands pass through at full DW; product width and truncation remain the kernel's concern.

Decomposition:
- Shared package fir_pkg holds:
  - FIR_DW=32, FIR_NTAP=11.
  - PHASE_RST=4'd1, PHASE_DONE=4'd11, PHASE_ACCEPT=4'd10.
  - typedef fir_word_t.
- One sub-module, fir_phase_ctr: the 1..11 wrap counter with decoded done/accept strobes. The kernel could later reuse it.
- History shift register and tap bank stay inline.

Test Plan:
- Phase alignment: release reset at cycle 0 and hold s_valid=1 → s_ready high at cycles 9, 20, 31. Kernel Done coincides with phase==11 at cycles 10, 21, 32.
- Impulse response:
  - Stimulus: taps[k]=k+1, send sample 1 followed by 0s, one per window.
  - Required response: successive y_valid results Y = 1, 2, …, 11, then 0.
  - The first y_valid result appears at cycle 21.
- Constant input: taps all 1, samples all 3 → after the history fills, every y_valid Y = 33.
- Producer stall:
  - Stimulus: drop s_valid for one window.
  - Required response: that window drives X=0 throughout, the corresponding Done has y_valid=0 and Y=0, and the history is unchanged.
- hist_clr with accept:
  - Stimulus: history full of 5, taps all 1; assert hist_clr together with accept of 7.
  - Required response: next result Y = 7.
- Mid-window reset: assert Resetn low at phase 5 of a live window → X=0, s_ready=0, y_valid=0 immediately. After release, the first s_ready occurs 9 cycles later.
